// File: rtl/dcache_pkg.sv
// Shared widths, FSM state type and defines for the data cache and its burst counter.
// Optional statistics counters are enabled with DCACHE_STATS_EN (see dcache_ctrl).
`ifndef DCACHE_PKG_DEFINES
`define DCACHE_PKG_DEFINES
`define DCACHE_BYTE_OFS 2'b00
`endif

package dcache_pkg;
  localparam int LINE_ADDR_LEN = 3;
  localparam int SET_ADDR_LEN  = 6;
  localparam int TAG_ADDR_LEN  = 30 - SET_ADDR_LEN - LINE_ADDR_LEN;

  localparam int LINE_WORDS = 2 ** LINE_ADDR_LEN;
  localparam int NUM_SETS   = 2 ** SET_ADDR_LEN;
  localparam int OFFSET_W   = LINE_ADDR_LEN;
  localparam int SET_W      = SET_ADDR_LEN;
  localparam int TAG_W      = TAG_ADDR_LEN;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    REFILL
  } state_t;
endpackage

// File: rtl/dcache_burst_ctr.sv
// Beat counter for line bursts: clears while idle, advances on each acknowledged beat,
// and flags the final beat of a line. Shared with the instruction cache.
module dcache_burst_ctr
  import dcache_pkg::*;
#(
  parameter int W = OFFSET_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_last
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt  = r_cnt;
  assign o_last = &r_cnt;
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache; DCacheMiss stalls the pipeline.
// Define DCACHE_STATS_EN to add the HitCnt/MissCnt statistics outputs.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RdReq,
  input  logic        WrReq,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        DCacheMiss,
  output logic        MemRdReq,
  output logic        MemWrReq,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWrData,
  input  logic [31:0] MemRdData,
  input  logic        MemAck
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] HitCnt,
  output logic [31:0] MissCnt
`endif
);
  logic [OFFSET_W-1:0] w_offset;
  logic [SET_W-1:0]    w_set;
  logic [TAG_W-1:0]    w_tag;
  logic [1:0]          w_unused;

  assign w_offset = Addr[OFFSET_W+1:2];
  assign w_set    = Addr[SET_W+OFFSET_W+1:OFFSET_W+2];
  assign w_tag    = Addr[31:SET_W+OFFSET_W+2];
  assign w_unused = Addr[1:0];

  state_t r_state, w_next;

  logic [TAG_W-1:0]    r_tag  [NUM_SETS];
  logic [31:0]         r_line [NUM_SETS][LINE_WORDS];
  logic [NUM_SETS-1:0] r_valid, r_dirty;

  logic [OFFSET_W-1:0] w_cnt;
  logic                w_last, w_idle, w_req, w_hit, w_beat_done;

  assign w_idle      = (r_state == IDLE);
  assign w_req       = RdReq | WrReq;
  assign w_hit       = r_valid[w_set] && (r_tag[w_set] == w_tag);
  assign w_beat_done = MemAck && !w_idle;

  dcache_burst_ctr #(.W(OFFSET_W)) u_burst_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_idle),
    .i_inc  (w_beat_done),
    .o_cnt  (w_cnt),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req && !w_hit) w_next = (r_valid[w_set] && r_dirty[w_set]) ? WB : REFILL;
      end
      WB:      if (w_beat_done && w_last) w_next = REFILL;
      REFILL:  if (w_beat_done && w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      case (r_state)
        IDLE:   if (WrReq && w_hit) r_dirty[w_set] <= 1'b1;
        WB:     if (w_beat_done && w_last) r_dirty[w_set] <= 1'b0;
        REFILL: begin
          if (w_beat_done && w_last) begin
            r_valid[w_set] <= 1'b1;
            r_dirty[w_set] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Line data and tags are deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (w_idle && WrReq && w_hit) r_line[w_set][w_offset] <= WrData;
    if (r_state == REFILL && w_beat_done) begin
      r_line[w_set][w_cnt] <= MemRdData;
      if (w_last) r_tag[w_set] <= w_tag;
    end
  end

  always_comb begin
    RdData     = '0;
    DCacheMiss = 1'b0;
    MemRdReq   = 1'b0;
    MemWrReq   = 1'b0;
    MemAddr    = '0;
    MemWrData  = '0;
    if (rst_n) begin
      DCacheMiss = !w_idle || (w_req && !w_hit);
      if (w_idle && RdReq && !WrReq && w_hit) RdData = r_line[w_set][w_offset];
      case (r_state)
        WB: begin
          MemWrReq  = 1'b1;
          MemAddr   = {r_tag[w_set], w_set, w_cnt, `DCACHE_BYTE_OFS};
          MemWrData = r_line[w_set][w_cnt];
        end
        REFILL: begin
          MemRdReq = 1'b1;
          MemAddr  = {w_tag, w_set, w_cnt, `DCACHE_BYTE_OFS};
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_idle && w_req && w_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
      if (w_idle && w_next != IDLE) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign HitCnt  = r_hit_cnt;
  assign MissCnt = r_miss_cnt;
`endif
endmodule
